// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and its helpers.
//   state_e     : loader state encoding
//   HALT_WORD   : instruction that terminates every program image
//   INST_MEM    : default instruction memory depth in words
//   ADDR_SHIFT  : word index to byte address shift
package imem_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CHK  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  localparam logic [31:0] HALT_WORD  = 32'hB4221820;
  localparam int unsigned INST_MEM   = 64;
  localparam int unsigned ADDR_SHIFT = 2;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// 4-byte MSB-first packer. Keeps the first three bytes of a word and presents
// the complete word combinationally together with the fourth byte, so that
// the consumer can register the word on the very edge that accepts its last
// byte.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   clear_i         : drop any partial word and restart at byte 0
//   accept_i        : byte_i is consumed this cycle
//   byte_i          : incoming stream byte
//   word_o          : assembled word (valid when word_valid_o is high)
//   word_valid_o    : this accept completes a word
module imem_loader_byte_packer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (accept_i) begin
      shift_d = {shift_q[15:0], byte_i};
      cnt_d   = cnt_q + 2'd1;  // wraps 3 -> 0
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word_o       = {shift_q, byte_i};
  assign word_valid_o = accept_i && !clear_i && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: turns a big-endian byte stream into 32-bit word
// writes at ascending word-aligned addresses, stops at HALT_WORD and then
// releases the CPU (cpu_run_o). Overflowing the memory ends in the error state.
// Optional build macro IMEM_LOADER_CHECKSUM_EN: after HALT four more bytes
// carry the expected 32-bit wrapping sum of all written words; a mismatch
// ends in the error state and raises chk_fail_o.
// Ports:
//   clk_i, reset_ni          : clock, asynchronous active-low reset
//   start_i                  : begin a load (ignored while busy)
//   in_byte_i/in_valid_i     : byte stream in, in_ready_o handshake out
//   mem_we_o/addr_o/wdata_o  : single-cycle word write port
//   busy_o, done_o, error_o  : load status levels; cpu_run_o mirrors done_o
//   chk_fail_o               : checksum mismatch (checksum builds only)
//   word_count_o             : words written in the current load
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned SIZE = INST_MEM
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  start_i,
  input  logic [7:0]            in_byte_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic                  cpu_run_o,
`ifdef IMEM_LOADER_CHECKSUM_EN
  output logic                  chk_fail_o,
`endif
  output logic [$clog2(SIZE):0] word_count_o
);

  localparam int CW = $clog2(SIZE) + 1;

  state_e         state_q, state_d;
  logic [CW-1:0]  wc_q, wc_d;
  logic           we_q, we_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           accept, pk_clear, word_vld;
  logic [31:0]    word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]    sum_q, sum_d;
  logic           chkf_q, chkf_d;
`endif

  assign in_ready_o = (state_q == S_LOAD) || (state_q == S_CHK);
  assign accept     = in_valid_i && in_ready_o;

  imem_loader_byte_packer u_packer (
    .clk_i        (clk_i),
    .rst_ni       (reset_ni),
    .clear_i      (pk_clear),
    .accept_i     (accept),
    .byte_i       (in_byte_i),
    .word_o       (word),
    .word_valid_o (word_vld)
  );

  always_comb begin
    state_d  = state_q;
    wc_d     = wc_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    pk_clear = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d    = sum_q;
    chkf_d   = chkf_q;
`endif
    case (state_q)
      S_LOAD: begin
        if (word_vld) begin
          // HALT always fits: the last slot is reserved for it.
          if (word == HALT_WORD || wc_q != CW'(SIZE - 1)) begin
            we_d    = 1'b1;
            addr_d  = 32'(wc_q) << ADDR_SHIFT;
            wdata_d = word;
            wc_d    = wc_q + CW'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d   = sum_q + word;
            if (word == HALT_WORD) state_d = S_CHK;
`else
            if (word == HALT_WORD) state_d = S_DONE;
`endif
          end else begin
            state_d = S_ERR;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (word_vld) begin
          if (word == sum_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
            chkf_d  = 1'b1;
          end
        end
      end
`endif
      default: begin
        // IDLE, DONE and ERR all restart on start.
        if (start_i) begin
          state_d  = S_LOAD;
          wc_d     = '0;
          pk_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d    = '0;
          chkf_d   = 1'b0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      wc_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
      chkf_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      chkf_q  <= chkf_d;
`endif
    end
  end

  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign word_count_o = wc_q;
  assign busy_o       = in_ready_o;
  assign done_o       = (state_q == S_DONE);
  assign error_o      = (state_q == S_ERR);
  assign cpu_run_o    = done_o;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign chk_fail_o   = chkf_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int          SIZE = 64;
  localparam int          WCW  = $clog2(SIZE) + 1;
  localparam logic [31:0] HALT = 32'hB4221820;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [7:0]     in_byte;
  logic           in_valid;
  logic           in_ready, mem_we, busy, done, error, cpu_run;
  logic [31:0]    mem_addr, mem_wdata;
  logic [WCW-1:0] word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic           chk_fail;
`endif

  int tests = 0;
  int fails = 0;

  logic [31:0] prog[$];
  wr_t         got[$];
  wr_t         exp_wr[$];
  bit          exp_done, exp_err, exp_chkf, halted, timed_out;
  int          exp_wc, n_words;
  logic [31:0] chk_word;

  imem_loader #(.SIZE(SIZE)) dut (
    .clk_i        (clk),
    .reset_ni     (rst_n),
    .start_i      (start),
    .in_byte_i    (in_byte),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error),
    .cpu_run_o    (cpu_run),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .chk_fail_o   (chk_fail),
`endif
    .word_count_o (word_count)
  );

  always #5 clk = ~clk;

  // Write monitor: records every memory write the DUT issues.
  always @(negedge clk) begin
    if (mem_we === 1'b1) got.push_back({mem_addr, mem_wdata});
  end

  // Reference model: the program image decides which words land where.
  task automatic model_program(input logic [31:0] chk_delta);
    logic [31:0] sum;
    sum = '0;
    exp_wr.delete();
    exp_done = 0; exp_err = 0; exp_chkf = 0; halted = 0;
    exp_wc = 0; n_words = 0;
    foreach (prog[i]) begin
      n_words = i + 1;
      if (i == SIZE - 1 && prog[i] != HALT) begin
        exp_err = 1;
        break;
      end
      exp_wr.push_back({32'(i * 4), prog[i]});
      sum    = sum + prog[i];
      exp_wc = i + 1;
      if (prog[i] == HALT) begin
        halted   = 1;
        exp_done = 1;
        break;
      end
    end
    chk_word = sum + chk_delta;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (halted && chk_delta != 0) begin
      exp_done = 0; exp_err = 1; exp_chkf = 1;
    end
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input bit st);
    int t;
    bit r;
    t = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b1;
      in_byte  = b;
      start    = st;
      r        = in_ready;
      @(posedge clk);
      #1 start = 1'b0;
      t++;
    end while (!r && t < 200);
    if (!r) begin
      tests++; fails++; timed_out = 1;
      $display("FAIL byte_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, t);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap, input int st_idx);
    for (int k = 0; k < 4; k++) begin
      if (timed_out) return;
      repeat ($urandom_range(0, maxgap)) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      send_byte(w[31-8*k -: 8], k == st_idx);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic finish_stream();
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (halted) send_word(chk_word, 0, -1);
`endif
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_program(input int maxgap, input bit do_start);
    timed_out = 0;
    if (do_start) pulse_start();
    got.delete();
    for (int w = 0; w < n_words; w++) send_word(prog[w], maxgap, -1);
    finish_stream();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_byte = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({in_ready, mem_we, busy, done, error, cpu_run} !== 6'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b, required 000000", {in_ready, mem_we, busy, done, error, cpu_run});
    end
    tests++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || word_count !== '0) begin
      fails++; $display("FAIL reset_data: addr=%h wdata=%h wc=%0d, required 0", mem_addr, mem_wdata, word_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic(input string name, input int maxgap);
    prog = '{32'h8C080000, 32'h8C090020, HALT};
    model_program(0);
    run_program(maxgap, 1);
    tests++;
    if (got.size() !== exp_wr.size()) begin
      fails++; $display("FAIL %s_nwrites: got %0d, required %0d", name, got.size(), exp_wr.size());
    end
    foreach (exp_wr[i]) if (i < got.size()) begin
      tests++;
      if (got[i] !== exp_wr[i]) begin
        fails++; $display("FAIL %s_write%0d: got %h/%h, required %h/%h", name, i, got[i].a, got[i].d, exp_wr[i].a, exp_wr[i].d);
      end
    end
    tests++;
    if ({done, cpu_run, error, busy, in_ready} !== {exp_done, exp_done, exp_err, 2'b00}) begin
      fails++; $display("FAIL %s_status: got %b, required %b", name, {done, cpu_run, error, busy, in_ready}, {exp_done, exp_done, exp_err, 2'b00});
    end
    tests++;
    if (word_count !== WCW'(exp_wc)) begin
      fails++; $display("FAIL %s_wc: got %0d, required %0d", name, word_count, exp_wc);
    end
  endtask

  task automatic test_random_program();
    logic [31:0] w;
    prog.delete();
    repeat ($urandom_range(1, 10)) begin
      w = $urandom;
      if (w == HALT) w = w ^ 32'h1;
      prog.push_back(w);
    end
    prog.push_back(HALT);
    model_program(0);
    run_program(3, 1);
    tests++;
    if (got.size() !== exp_wr.size()) begin
      fails++; $display("FAIL rand_nwrites: got %0d, required %0d", got.size(), exp_wr.size());
    end
    foreach (exp_wr[i]) if (i < got.size()) begin
      tests++;
      if (got[i] !== exp_wr[i]) begin
        fails++; $display("FAIL rand_write%0d: got %h/%h, required %h/%h", i, got[i].a, got[i].d, exp_wr[i].a, exp_wr[i].d);
      end
    end
    tests++;
    if (done !== 1'b1 || word_count !== WCW'(exp_wc)) begin
      fails++; $display("FAIL rand_done: done=%b wc=%0d, required 1/%0d", done, word_count, exp_wc);
    end
  endtask

  task automatic test_overflow();
    prog.delete();
    repeat (SIZE) prog.push_back(32'h00000020);
    model_program(0);
    run_program(0, 1);
    tests++;
    if (got.size() !== exp_wr.size()) begin
      fails++; $display("FAIL ovf_nwrites: got %0d, required %0d", got.size(), exp_wr.size());
    end
    foreach (exp_wr[i]) if (i < got.size()) begin
      tests++;
      if (got[i] !== exp_wr[i]) begin
        fails++; $display("FAIL ovf_write%0d: got %h/%h, required %h/%h", i, got[i].a, got[i].d, exp_wr[i].a, exp_wr[i].d);
      end
    end
    tests++;
    if ({error, cpu_run, done, in_ready} !== {exp_err, 3'b000}) begin
      fails++; $display("FAIL ovf_status: err/run/done/rdy=%b, required %b", {error, cpu_run, done, in_ready}, {exp_err, 3'b000});
    end
  endtask

  task automatic test_reset_midload();
    timed_out = 0;
    pulse_start();
    send_word(32'h12345678, 0, -1);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    tests++;
    if ({in_ready, mem_we, busy, done, error, cpu_run} !== 6'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || word_count !== '0) begin
      fails++; $display("FAIL midreset_outputs: ctrl=%b addr=%h wdata=%h wc=%0d, required all 0", {in_ready, mem_we, busy, done, error, cpu_run}, mem_addr, mem_wdata, word_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    prog = '{32'h8C0A0004, HALT};
    model_program(0);
    run_program(1, 1);
    tests++;
    if (got.size() !== 2) begin
      fails++; $display("FAIL midreset_nwrites: got %0d, required 2", got.size());
    end
    foreach (exp_wr[i]) if (i < got.size()) begin
      tests++;
      if (got[i] !== exp_wr[i]) begin
        fails++; $display("FAIL midreset_write%0d: got %h/%h, required %h/%h", i, got[i].a, got[i].d, exp_wr[i].a, exp_wr[i].d);
      end
    end
  endtask

  task automatic test_start_ignored();
    prog = '{32'h01020304, 32'hA0B0C0D0, HALT};
    model_program(0);
    timed_out = 0;
    pulse_start();
    got.delete();
    send_word(prog[0], 0, 2);          // start coincides with a byte accept
    @(negedge clk); in_valid = 1'b0;
    pulse_start();                     // start alone while loading
    for (int w = 1; w < n_words; w++) send_word(prog[w], 1, -1);
    finish_stream();
    tests++;
    if (got.size() !== exp_wr.size()) begin
      fails++; $display("FAIL startign_nwrites: got %0d, required %0d", got.size(), exp_wr.size());
    end
    foreach (exp_wr[i]) if (i < got.size()) begin
      tests++;
      if (got[i] !== exp_wr[i]) begin
        fails++; $display("FAIL startign_write%0d: got %h/%h, required %h/%h", i, got[i].a, got[i].d, exp_wr[i].a, exp_wr[i].d);
      end
    end
    tests++;
    if (done !== 1'b1 || word_count !== WCW'(3)) begin
      fails++; $display("FAIL startign_done: done=%b wc=%0d, required 1/3", done, word_count);
    end
    // Restart from DONE.
    pulse_start();
    tests++;
    if ({word_count, busy, done, cpu_run} !== {WCW'(0), 3'b100}) begin
      fails++; $display("FAIL restart_state: wc=%0d busy=%b done=%b run=%b, required 0/1/0/0", word_count, busy, done, cpu_run);
    end
    prog = '{32'hCAFEF00D, HALT};
    model_program(0);
    run_program(2, 0);
    tests++;
    if (got.size() !== 2) begin
      fails++; $display("FAIL restart_nwrites: got %0d, required 2", got.size());
    end
    foreach (exp_wr[i]) if (i < got.size()) begin
      tests++;
      if (got[i] !== exp_wr[i]) begin
        fails++; $display("FAIL restart_write%0d: got %h/%h, required %h/%h", i, got[i].a, got[i].d, exp_wr[i].a, exp_wr[i].d);
      end
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    for (int pass = 0; pass < 2; pass++) begin
      prog = '{32'h00000020, HALT};
      model_program(32'(pass));
      run_program(pass * 2, 1);
      tests++;
      if (pass == 0 && chk_word !== 32'hB4221840) begin
        fails++; $display("FAIL chk_model: sum %h, required B4221840", chk_word);
      end
      tests++;
      if (got.size() !== 2) begin
        fails++; $display("FAIL chk%0d_nwrites: got %0d, required 2", pass, got.size());
      end
      tests++;
      if ({done, cpu_run, error, chk_fail, busy} !== {exp_done, exp_done, exp_err, exp_chkf, 1'b0}) begin
        fails++; $display("FAIL chk%0d_status: got %b, required %b", pass, {done, cpu_run, error, chk_fail, busy}, {exp_done, exp_done, exp_err, exp_chkf, 1'b0});
      end
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic("b2b", 0);
    test_basic("gaps", 5);
    test_random_program();
    test_overflow();
    test_reset_midload();
    test_start_ignored();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a big-endian byte stream over a valid/ready handshake.
- Packs the bytes into 32-bit instruction words and issues single-cycle word writes to the instruction memory write port at ascending word-aligned byte addresses.
- Stops after writing the HALT word (every program ends with it), then releases the CPU.
- Sits between the host/UART byte source and the instruction memory; the CPU is held off until the load completes.

Parameters:
- size, 64, instruction memory depth in words.
- data_width, 32, instruction word width; fixed at 32.
- HALT_WORD, 32'hB4221820, program terminator encoding.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load; ignored while busy.
- in_byte  in  8  stream byte, most significant byte of each word first.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction memory write strobe, one cycle per word.
- mem_addr  out  32  byte address; always word aligned, equal to word_index*4.
- mem_wdata  out  32  instruction word.
- busy  out  1  load in progress.
- done  out  1  level; load completed successfully.
- error  out  1  level; overflow or checksum failure.
- cpu_run  out  1  equals done; CPU held when low.
- word_count  out  $clog2(size)+1  words written so far in this load.

Behaviour:
- Reset, asynchronous and active-low: state=IDLE. in_ready, mem_we, busy, done, error and cpu_run are 0. mem_addr, mem_wdata and word_count are 0. Byte counter is 0.
- Any reset assertion mid-load aborts immediately. Words already written to memory are not cleared.
- States: IDLE, LOAD, CHK (CHECKSUM_EN builds only), DONE, ERR.
- IDLE/DONE/ERR -> LOAD on start. On entry: word_count=0, byte counter=0, done=0, error=0, checksum accumulator=0.
- LOAD:
  - in_ready=1 and busy=1.
  - A byte is accepted when in_valid&&in_ready; accepted bytes shift into the word, MSB first.
  - The byte counter wraps 3->0.
- On the 4th accepted byte of a word, the cycle after the accept:
  - mem_we=1 for exactly one cycle, with mem_addr=word_count*4 and mem_wdata set to the assembled word.
  - word_count increments in that same cycle.
  - mem_addr and mem_wdata hold their last values after the pulse.
  - in_ready stays 1 during the write cycle, so back-to-back bytes run at 1 byte/clk with no bubbles.
- Assembled word == HALT_WORD: the write still occurs. State goes to DONE, or to CHK when CHECKSUM_EN is defined; in_ready drops on the next edge.
- Overflow: if the assembled word is not HALT_WORD and word_count == size-1 (the last slot), the write is suppressed, state=ERR, and error=1.
- DONE: done=1, cpu_run=1, busy=0, in_ready=0.
- ERR: error=1, busy=0, in_ready=0, cpu_run=0.
- Simultaneous start and byte accept while in LOAD: start is ignored and the byte is accepted.
- in_valid while in_ready=0: no effect; the source holds the byte.
- A partial word (1-3 bytes) followed by a stall: it waits indefinitely, with no timeout.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A 32-bit wrapping sum of all written words, HALT included, accumulates during LOAD.
  - After HALT the loader enters CHK and accepts 4 further bytes, MSB first, as the expected sum. These bytes are not written to memory.
  - Match -> DONE. Mismatch -> ERR.
  - Extra output chk_fail (1 bit, reset 0) is set on mismatch.
- Not defined: no CHK state and no chk_fail port; HALT goes directly to DONE.

Decomposition:
- Shared package imem_pkg holds:
  - loader state enum (IDLE, LOAD, CHK, DONE, ERR)
  - HALT_WORD constant 32'hB4221820
  - INST_MEM default depth 64
  - word-to-byte address shift constant 2
- One natural sub-module: byte_packer. It is a 4-byte MSB-first shift register with byte counter and a word_valid pulse, reusable for a future data-memory loader.

Test Plan:
- Stream 8C 08 00 00, 8C 09 00 20, B4 22 18 20 back-to-back -> three mem_we pulses: addr 0/4/8, data 8C080000 / 8C090020 / B4221820. Then done=1, cpu_run=1, word_count=3, in_ready=0.
- Same stream with in_valid gaps of 0-5 cycles (random) -> identical writes; exactly one mem_we per 4 accepted bytes.
- Stream 64 non-HALT words (00000020) -> 63 writes, addrs 0..248. The 64th write is suppressed; error=1, cpu_run=0.
- Assert reset after 6 bytes, release, pulse start, send a 2-word program ending in HALT -> outputs 0 during reset. The new load writes at addr 0 and 4; no stale partial bytes appear.
- Pulse start mid-load -> ignored, no restart. Pulse start in DONE -> word_count=0, a new load begins at addr 0.
- IMEM_LOADER_CHECKSUM_EN: words 00000020 and B4221820, then sum B4221840 -> done=1. Sending B4221841 instead -> error=1, chk_fail=1, and no write for the checksum bytes.
